scan_mux_n: RTL and testbench

//   Parametrised N-channel, WIDTH-bit registered channel multiplexer for the display/status path.
//   Two modes:
//   - Manual: CONTROL selects the channel.
//   - Auto-scan: an internal dwell counter steps through the channels round-robin, e.g. for a time-multiplexed 7-segment drive.

---
 rtl/scan_mux_n_if.sv | 26 ++
 rtl/scan_mux_n.sv | 138 +++++++++++++
 tb/tb_scan_mux_n.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/scan_mux_n_if.sv
// Channel-mux bus: mode/select/data inputs and the registered display outputs.
interface scan_mux_n_if #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) ();

  logic                      MODE;
  logic [SEL_W-1:0]          CONTROL;
  logic [WIDTH*CHANNELS-1:0] IN;
  logic [WIDTH-1:0]          OUT;
  logic [SEL_W-1:0]          ACTIVE;
  logic [CHANNELS-1:0]       ONEHOT;
  logic                      STROBE;

  modport master (
    output MODE, CONTROL, IN,
    input  OUT, ACTIVE, ONEHOT, STROBE
  );

  modport slave (
    input  MODE, CONTROL, IN,
    output OUT, ACTIVE, ONEHOT, STROBE
  );

endinterface

// File: rtl/scan_mux_n.sv
// N-channel registered display multiplexer with manual select and round-robin auto-scan.
// Optional feature: define SCAN_BLANK_EN to insert BLANK dark cycles between scanned
// channels (anti-ghosting). Without it, channels switch back-to-back and BLANK is ignored.
module scan_mux_n #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned DWELL    = 100000,
  parameter int unsigned DWELL_W  = 17,
  parameter int unsigned BLANK    = 8
) (
  input logic         CLK,
  input logic         RESET,
  scan_mux_n_if.slave bus
);

  typedef enum logic [1:0] {StMan, StShow, StBlk} state_e;

  localparam logic [SEL_W-1:0]   LastCh    = SEL_W'(CHANNELS - 1);
  localparam logic [DWELL_W-1:0] DwellLast = DWELL_W'(DWELL - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [DWELL_W-1:0] BlankLast = DWELL_W'(BLANK - 1);
`else
  logic unused_blank;
  assign unused_blank = ^BLANK;
`endif

  state_e               state_q, state_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]     active_q, active_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [CHANNELS-1:0]  onehot_q, onehot_d;
  logic                 strobe_q, strobe_d;
  logic                 blank_d;
  logic [SEL_W-1:0]     next_ch;
  logic                 in_range;

  // Round-robin successor, wrapping at the real channel count rather than 2**SEL_W.
  assign next_ch  = (active_q == LastCh) ? '0 : active_q + 1'b1;
  assign in_range = (active_q <= LastCh);

  // Next-state: mode is sampled every cycle and always takes priority over a scan step.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    blank_d  = 1'b0;
    unique case (state_q)
      StMan: begin
        cnt_d = '0;
        if (bus.MODE) begin
          state_d  = StShow;
          active_d = in_range ? active_q : '0;
        end else begin
          active_d = bus.CONTROL;
        end
      end
      StShow: begin
        if (!bus.MODE) begin
          state_d  = StMan;
          cnt_d    = '0;
          active_d = bus.CONTROL;
        end else if (cnt_q == DwellLast) begin
          cnt_d = '0;
`ifdef SCAN_BLANK_EN
          state_d = StBlk;
          blank_d = 1'b1;
`else
          active_d = next_ch;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SCAN_BLANK_EN
      StBlk: begin
        if (!bus.MODE) begin
          state_d  = StMan;
          cnt_d    = '0;
          active_d = bus.CONTROL;
        end else if (cnt_q == BlankLast) begin
          state_d  = StShow;
          cnt_d    = '0;
          active_d = next_ch;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          blank_d = 1'b1;
        end
      end
`endif
      default: begin
        state_d = StMan;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next ACTIVE; an out-of-range select matches no channel and
  // therefore yields zero data and an all-zero one-hot.
  always_comb begin
    out_d    = '0;
    onehot_d = '0;
    if (!blank_d) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (active_d == k[SEL_W-1:0]) begin
          out_d       = bus.IN[k*WIDTH +: WIDTH];
          onehot_d[k] = 1'b1;
        end
      end
    end
    strobe_d = (active_d != active_q);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StMan;
      cnt_q    <= '0;
      active_q <= '0;
      out_q    <= '0;
      onehot_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      out_q    <= out_d;
      onehot_q <= onehot_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.OUT    = out_q;
  assign bus.ACTIVE = active_q;
  assign bus.ONEHOT = onehot_q;
  assign bus.STROBE = strobe_q;

endmodule

// File: tb/tb_scan_mux_n.sv
// Directed bench for scan_mux_n: manual select, scan wrap, mode switching, out-of-range
// select, asynchronous reset and (with SCAN_BLANK_EN) blank insertion.
module tb_scan_mux_n;

  localparam int WIDTH   = 5;
  localparam int CH      = 4;
  localparam int SEL_W   = 2;
  localparam int DWELL   = 4;
  localparam int DWELL_W = 3;
  localparam int BLANK   = 2;
`ifdef SCAN_BLANK_EN
  localparam int P       = DWELL + BLANK;
  localparam bit BlankEn = 1'b1;
`else
  localparam int P       = DWELL;
  localparam bit BlankEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [4:0] chd [4];

  always #5 clk = ~clk;

  scan_mux_n_if #(.WIDTH(WIDTH), .CHANNELS(4), .SEL_W(SEL_W)) bus0 ();
  scan_mux_n_if #(.WIDTH(WIDTH), .CHANNELS(3), .SEL_W(SEL_W)) bus1 ();

  scan_mux_n #(
    .WIDTH(WIDTH), .CHANNELS(4), .SEL_W(SEL_W),
    .DWELL(DWELL), .DWELL_W(DWELL_W), .BLANK(BLANK)
  ) u_dut0 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus0)
  );

  scan_mux_n #(
    .WIDTH(WIDTH), .CHANNELS(3), .SEL_W(SEL_W),
    .DWELL(DWELL), .DWELL_W(DWELL_W), .BLANK(BLANK)
  ) u_dut1 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in0();
    bus0.IN = {chd[3], chd[2], chd[1], chd[0]};
  endtask

  // Expected scan behaviour i cycles after SHOW entry starting on channel s.
  function automatic int m_act(input int s, input int i);
    return (s + i / P) % CH;
  endfunction

  function automatic bit m_blank(input int i);
    return BlankEn && ((i % P) >= DWELL);
  endfunction

  task automatic chk_scan(input string tag, input int s, input int i);
    int a;
    bit b;
    a = m_act(s, i);
    b = m_blank(i);
    chk($sformatf("%s[%0d].active", tag, i), 32'(bus0.ACTIVE), a);
    chk($sformatf("%s[%0d].strobe", tag, i), 32'(bus0.STROBE), 32'((i > 0) && (i % P == 0)));
    chk($sformatf("%s[%0d].onehot", tag, i), 32'(bus0.ONEHOT), b ? 0 : (1 << a));
    chk($sformatf("%s[%0d].out", tag, i), 32'(bus0.OUT), b ? 0 : 32'(chd[a]));
  endtask

  initial begin
    chd[0] = 5'h1F; chd[1] = 5'h07; chd[2] = 5'h0A; chd[3] = 5'h13;
    bus0.MODE = 1'b0; bus0.CONTROL = '0; set_in0();
    bus1.MODE = 1'b0; bus1.CONTROL = '0; bus1.IN = {5'h0A, 5'h07, 5'h1F};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out",    32'(bus0.OUT),    0);
    chk("rst.active", 32'(bus0.ACTIVE), 0);
    chk("rst.onehot", 32'(bus0.ONEHOT), 0);
    chk("rst.strobe", 32'(bus0.STROBE), 0);

    // Manual select
    rst = 1'b0;
    bus0.CONTROL = 2'd2;
    step();
    chk("man2.out",    32'(bus0.OUT),    5'h0A);
    chk("man2.active", 32'(bus0.ACTIVE), 2);
    chk("man2.onehot", 32'(bus0.ONEHOT), 4'b0100);
    chk("man2.strobe", 32'(bus0.STROBE), 1);
    step();
    chk("man2_hold.strobe", 32'(bus0.STROBE), 0);
    chk("man2_hold.active", 32'(bus0.ACTIVE), 2);
    bus0.CONTROL = 2'd0;
    step();
    chk("man0.out",    32'(bus0.OUT),    5'h1F);
    chk("man0.strobe", 32'(bus0.STROBE), 1);

    // Out-of-range select on the 3-channel instance, then entry into scan
    bus1.CONTROL = 2'd3;
    step();
    chk("oor.out",    32'(bus1.OUT),    0);
    chk("oor.onehot", 32'(bus1.ONEHOT), 0);
    chk("oor.active", 32'(bus1.ACTIVE), 3);
    chk("oor.strobe", 32'(bus1.STROBE), 1);
    bus1.MODE = 1'b1;
    step();
    chk("oor_scan.active", 32'(bus1.ACTIVE), 0);
    chk("oor_scan.strobe", 32'(bus1.STROBE), 1);
    chk("oor_scan.onehot", 32'(bus1.ONEHOT), 3'b001);
    chk("oor_scan.out",    32'(bus1.OUT),    5'h1F);
    bus1.MODE = 1'b0;

    // Scan wrap, stopping at channel 1 with the counter at 2
    bus0.MODE = 1'b1;
    for (int i = 0; i <= 5 * P + 2; i++) begin
      step();
      chk_scan("scan", 0, i);
    end

    // Drop to manual mid-dwell, then resume scanning from the manual channel
    bus0.MODE = 1'b0;
    bus0.CONTROL = 2'd3;
    step();
    chk("drop.active", 32'(bus0.ACTIVE), 3);
    chk("drop.out",    32'(bus0.OUT),    5'h13);
    chk("drop.onehot", 32'(bus0.ONEHOT), 4'b1000);
    chk("drop.strobe", 32'(bus0.STROBE), 1);
    bus0.MODE = 1'b1;
    for (int i = 0; i <= P; i++) begin
      step();
      chk_scan("resume", 3, i);
    end

    // Live data inside a dwell
    chd[0] = 5'h05; set_in0();
    step();
    chk("live.out",    32'(bus0.OUT),    5'h05);
    chk("live.active", 32'(bus0.ACTIVE), 0);
    chd[0] = 5'h1F; set_in0();
    step();
    step();

    // Mode drop on the last dwell cycle: manual select wins, no scan step
    bus0.MODE = 1'b0;
    bus0.CONTROL = 2'd2;
    step();
    chk("adv_drop.active", 32'(bus0.ACTIVE), 2);
    chk("adv_drop.out",    32'(bus0.OUT),    5'h0A);
    chk("adv_drop.strobe", 32'(bus0.STROBE), 1);

`ifdef SCAN_BLANK_EN
    // Mode drop during the blank gap goes straight to manual
    bus0.MODE = 1'b1;
    repeat (DWELL + 1) step();
    chk("blk.out",    32'(bus0.OUT),    0);
    chk("blk.onehot", 32'(bus0.ONEHOT), 0);
    chk("blk.active", 32'(bus0.ACTIVE), 2);
    bus0.MODE = 1'b0;
    bus0.CONTROL = 2'd1;
    step();
    chk("blk_drop.active", 32'(bus0.ACTIVE), 1);
    chk("blk_drop.out",    32'(bus0.OUT),    5'h07);
    chk("blk_drop.onehot", 32'(bus0.ONEHOT), 4'b0010);
    chk("blk_drop.strobe", 32'(bus0.STROBE), 1);
`endif

    // Asynchronous reset mid-dwell, between clock edges
    bus0.MODE = 1'b1;
    step();
    step();
    step();
    #3 rst = 1'b1;
    #1;
    chk("arst.out",    32'(bus0.OUT),    0);
    chk("arst.active", 32'(bus0.ACTIVE), 0);
    chk("arst.onehot", 32'(bus0.ONEHOT), 0);
    chk("arst.strobe", 32'(bus0.STROBE), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i <= P; i++) begin
      step();
      chk_scan("rst_scan", 0, i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
